// File: rtl/spad_frame_packer.sv
// Packs SPAD pixel bytes from the frame controller's read window into 32-bit words
// and streams one AXI-Stream packet per frame: FrameId header, data words, tlast.
module spad_frame_packer #(
    parameter int DATA_LATENCY      = 1,
    parameter int SAMPLES_PER_FRAME = 1024,
    parameter int FIFO_DEPTH        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable,
    input  logic [2:0]  RowSelect,
    input  logic [5:0]  ColSelect,
    input  logic        HighLowRows,
    input  logic [31:0] FrameId,
    input  logic [7:0]  SpadData,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] FramesSent,
    output logic [15:0] DroppedWords
);

    localparam int CW = $clog2(SAMPLES_PER_FRAME);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(SAMPLES_PER_FRAME - 1);
    localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

    logic [DATA_LATENCY-1:0]       re_pipe_q;
    logic [DATA_LATENCY-1:0][9:0]  addr_pipe_q;
    logic [DATA_LATENCY-1:0][31:0] fid_pipe_q;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   word_q, word_d;
    logic          corrupt_q, corrupt_d;
    logic          pend_q, pend_d;
    logic [31:0]   pend_fid_q, pend_fid_d;
    logic [15:0]   frames_q, frames_d;
    logic [15:0]   dropped_q, dropped_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [33:0]   mem_q [FIFO_DEPTH];

    logic          sample_v, frame_start;
    logic [9:0]    addr_dly;
    logic [31:0]   fid_dly;
    logic          wr_en, wr_last, wr_user, admit, push, pop;
    logic [31:0]   wr_data;
    logic [33:0]   head;

    // Address, strobe and FrameId are delayed so they line up with SpadData.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            re_pipe_q   <= '0;
            addr_pipe_q <= '0;
            fid_pipe_q  <= '0;
        end else begin
            re_pipe_q[0]   <= ReadEnable;
            addr_pipe_q[0] <= {HighLowRows, RowSelect, ColSelect};
            fid_pipe_q[0]  <= FrameId;
            for (int i = 1; i < DATA_LATENCY; i++) begin
                re_pipe_q[i]   <= re_pipe_q[i-1];
                addr_pipe_q[i] <= addr_pipe_q[i-1];
                fid_pipe_q[i]  <= fid_pipe_q[i-1];
            end
        end
    end

    assign sample_v    = re_pipe_q[DATA_LATENCY-1];
    assign addr_dly    = addr_pipe_q[DATA_LATENCY-1];
    assign fid_dly     = fid_pipe_q[DATA_LATENCY-1];
    assign frame_start = (addr_dly == 10'd0);

    always_comb begin
        cnt_d      = cnt_q;
        word_d     = word_q;
        corrupt_d  = corrupt_q;
        pend_d     = pend_q;
        pend_fid_d = pend_fid_q;
        wr_en      = 1'b0;
        wr_data    = 32'd0;
        wr_last    = 1'b0;
        wr_user    = 1'b0;

        // Header deferred by a truncation flush goes out one cycle later.
        if (pend_q) begin
            wr_en   = 1'b1;
            wr_data = pend_fid_q;
            pend_d  = 1'b0;
        end

        if (sample_v) begin
            if (frame_start) begin
                if (cnt_q != '0) begin
                    wr_en      = 1'b1;
                    wr_data    = word_q;
                    wr_last    = 1'b1;
                    wr_user    = 1'b1;
                    pend_d     = 1'b1;
                    pend_fid_d = fid_dly;
                    corrupt_d  = 1'b0;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = fid_dly;
                end
                word_d = {24'd0, SpadData};
                cnt_d  = CW'(1);
            end else if (cnt_q != '0) begin
                word_d[{cnt_q[1:0], 3'b000} +: 8] = SpadData;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q[1:0] == 2'd3) begin
                    wr_en   = 1'b1;
                    wr_data = word_d;
                    word_d  = 32'd0;
                    if (cnt_q == LAST_IDX) begin
                        wr_last   = 1'b1;
                        wr_user   = corrupt_q;
                        cnt_d     = '0;
                        corrupt_d = 1'b0;
                    end
                end
            end
        end

        // One slot is kept in reserve so a frame's tlast word can always land.
        admit = wr_last ? (count_q != DEPTH) : (count_q <= DEPTH - (AW+1)'(2));
        push  = wr_en & admit;
        if (wr_en && !admit && !wr_last) begin
            corrupt_d = 1'b1;
        end

        frames_d  = frames_q + {15'd0, push & wr_last};
        dropped_d = dropped_q;
        if (wr_en && !admit && dropped_q != 16'hFFFF) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    assign pop = (count_q != '0) & m_axis_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            word_q     <= '0;
            corrupt_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_fid_q <= '0;
            frames_q   <= '0;
            dropped_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            corrupt_q  <= corrupt_d;
            pend_q     <= pend_d;
            pend_fid_q <= pend_fid_d;
            frames_q   <= frames_d;
            dropped_q  <= dropped_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {wr_user, wr_last, wr_data};
    end

    assign head          = mem_q[rd_ptr_q];
    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? head[31:0] : 32'd0;
    assign m_axis_tlast  = m_axis_tvalid & head[32];
    assign m_axis_tuser  = m_axis_tvalid & head[33];
    assign FramesSent    = frames_q;
    assign DroppedWords  = dropped_q;

endmodule
